// File: rtl/dmem_responder.sv
// Single-port data memory responder: byte/half/word loads and stores with a fixed response latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned HALF/WORD accesses instead of force-aligning them.
module dmem_lane #(
    parameter int LANE = 0
) (
    input  logic       en,
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic [7:0] w_b0,
    input  logic [7:0] w_b1,
    input  logic [7:0] w_lane,
    output logic       we,
    output logic [7:0] wd
);
    localparam logic [1:0] LANE_ID = 2'(LANE);

    always_comb begin
        we = 1'b0;
        wd = w_b0;
        case (size)
            2'b00: we = en && (addr_lo == LANE_ID);
            2'b01: begin
                we = en && (addr_lo[1] == LANE_ID[1]);
                wd = LANE_ID[0] ? w_b1 : w_b0;
            end
            2'b10: begin
                we = en;
                wd = w_lane;
            end
            default: we = 1'b0;
        endcase
    end
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_we,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int NUM_LANES = 4;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [NUM_LANES-1:0][7:0] mem [DEPTH_WORDS];

    state_t                    state;
    logic [2:0]                cnt;
    logic                      accept;
    logic                      range_err;
    logic                      acc_err;
    logic [1:0]                eff_lo;
    logic [AW-1:0]             widx;
    logic [NUM_LANES-1:0][7:0] rd_word;
    logic [7:0]                rd_byte;
    logic [15:0]               rd_half;
    logic                      st_en;
    logic [NUM_LANES-1:0]      lane_we;
    logic [NUM_LANES-1:0][7:0] lane_wd;
    rsp_t                      rsp_d;

    assign accept    = req_valid && req_ready && resetn;
    assign range_err = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign widx      = req_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign acc_err  = (req_size == 2'b11) || range_err || misalign;
    assign eff_lo   = req_addr[1:0];
`else
    assign acc_err  = (req_size == 2'b11) || range_err;
    assign eff_lo   = (req_size == 2'b01) ? {req_addr[1], 1'b0} :
                      (req_size == 2'b10) ? 2'b00 : req_addr[1:0];
`endif

    assign st_en   = accept && req_we && !acc_err;
    assign rd_word = mem[widx];
    assign rd_byte = rd_word[eff_lo];
    assign rd_half = eff_lo[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        dmem_lane #(.LANE(l)) u_lane (
            .en      (st_en),
            .size    (req_size),
            .addr_lo (eff_lo),
            .w_b0    (req_wdata[7:0]),
            .w_b1    (req_wdata[15:8]),
            .w_lane  (req_wdata[8*l +: 8]),
            .we      (lane_we[l]),
            .wd      (lane_wd[l])
        );
    end

    // Load result is formed at accept so the array is read before any later store lands.
    always_comb begin
        rsp_d.err   = acc_err;
        rsp_d.rdata = '0;
        if (!acc_err && !req_we) begin
            case (req_size)
                2'b00:   rsp_d.rdata = req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                2'b01:   rsp_d.rdata = req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
                2'b10:   rsp_d.rdata = rd_word;
                default: rsp_d.rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++)
            if (lane_we[l]) mem[widx][l] <= lane_wd[l];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= rsp_d.rdata;
                        rsp_err   <= rsp_d.err;
                        cnt       <= 3'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences, and random traffic vs. a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] mdl [4*DEPTH];

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic        u;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vt [22];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_we(req_we), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-addressed array, access = nbytes starting at (aligned) address.
    task automatic model(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic u,
                         input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
        int unsigned nb, base;
        logic [31:0] v;
        nb   = 1 << sz;
        eerr = (sz == 2'b11) || (a >= 4*DEPTH);
        if (TRAP && (a % nb) != 0) eerr = 1'b1;
        erd = '0;
        if (eerr) return;
        base = a - (a % nb);
        if (we) begin
            for (int k = 0; k < int'(nb); k++) mdl[base + k] = wd[8*k +: 8];
        end else begin
            v = '0;
            for (int k = 0; k < int'(nb); k++) v = v | (32'(mdl[base + k]) << (8*k));
            if (!u && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            erd = v;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic u, input logic [31:0] wd);
        req_we = we; req_size = sz; req_addr = a; req_unsigned = u; req_wdata = wd;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic u,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int lat;
        @(negedge clk);
        wait_ready();
        drive(we, sz, a, u, wd);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // junk store while busy must be ignored
        drive(1'b1, 2'b10, 32'($urandom_range(0, 4*DEPTH-1)), 1'b0, $urandom);
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata;
        er = rsp_err;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic u,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output logic [31:0] erd, output logic eer);
        xact(we, sz, a, u, wd, rd, er);
        model(we, sz, a, u, wd, erd, eer);
    endtask

    task automatic reset_in_wait(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] erd;
        logic eer, seen;
        @(negedge clk);
        wait_ready();
        drive(we, 2'b10, a, 1'b0, wd);
        req_valid = 1'b1;
        @(posedge clk);
        model(we, 2'b10, a, 1'b0, wd, erd, eer);
        @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_wait_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd0);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); seen = seen | rsp_valid; end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, erd, a;
        logic er, eer;
        logic [1:0] sz;

        vt[0]  = '{1'b1, 2'd2, 32'h10,  1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 2'd0, 32'h13,  1'b0, 32'h0,        32'hFFFFFFDE, 1'b0};
        vt[2]  = '{1'b0, 2'd0, 32'h13,  1'b1, 32'h0,        32'h000000DE, 1'b0};
        vt[3]  = '{1'b0, 2'd1, 32'h12,  1'b0, 32'h0,        32'hFFFFDEAD, 1'b0};
        vt[4]  = '{1'b1, 2'd0, 32'h11,  1'b0, 32'hFFFFFF55, 32'h0,        1'b0};
        vt[5]  = '{1'b0, 2'd2, 32'h10,  1'b0, 32'h0,        32'hDEAD55EF, 1'b0};
        vt[6]  = '{1'b1, 2'd1, 32'h12,  1'b0, 32'h1234A5A5, 32'h0,        1'b0};
        vt[7]  = '{1'b0, 2'd2, 32'h10,  1'b0, 32'h0,        32'hA5A555EF, 1'b0};
        vt[8]  = TRAP ? '{1'b0, 2'd2, 32'h12, 1'b0, 32'h0, 32'h0, 1'b1}
                      : '{1'b0, 2'd2, 32'h12, 1'b0, 32'h0, 32'hA5A555EF, 1'b0};
        vt[9]  = '{1'b0, 2'd1, 32'h12,  1'b1, 32'h0,        32'h0000A5A5, 1'b0};
        vt[10] = '{1'b0, 2'd1, 32'h12,  1'b0, 32'h0,        32'hFFFFA5A5, 1'b0};
        vt[11] = '{1'b1, 2'd1, 32'h11,  1'b0, 32'h00001234, 32'h0,        TRAP};
        vt[12] = '{1'b0, 2'd2, 32'h10,  1'b0, 32'h0,        TRAP ? 32'hA5A555EF : 32'hA5A51234, 1'b0};
        vt[13] = '{1'b0, 2'd3, 32'h10,  1'b0, 32'h0,        32'h0,        1'b1};
        vt[14] = '{1'b0, 2'd2, 32'h100, 1'b0, 32'h0,        32'h0,        1'b1};
        vt[15] = '{1'b1, 2'd3, 32'h0,   1'b0, 32'h12345678, 32'h0,        1'b1};
        vt[16] = '{1'b1, 2'd2, 32'h100, 1'b0, 32'h12345678, 32'h0,        1'b1};
        vt[17] = '{1'b1, 2'd0, 32'hFFFFFFFF, 1'b0, 32'h77,  32'h0,        1'b1};
        vt[18] = '{1'b0, 2'd2, 32'h0,   1'b0, 32'h0,        32'hC0DE0000, 1'b0};
        vt[19] = '{1'b0, 2'd2, 32'hFC,  1'b0, 32'h0,        32'hC0DE003F, 1'b0};
        vt[20] = '{1'b0, 2'd0, 32'hFF,  1'b1, 32'h0,        32'h000000C0, 1'b0};
        vt[21] = '{1'b0, 2'd0, 32'hFF,  1'b0, 32'h0,        32'hFFFFFFC0, 1'b0};

        resetn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++)
            run(1'b1, 2'b10, 32'(4*i), 1'b0, 32'hC0DE0000 | 32'(i), rd, er, erd, eer);

        for (int i = 0; i < 22; i++) begin
            run(vt[i].we, vt[i].sz, vt[i].addr, vt[i].u, vt[i].wd, rd, er, erd, eer);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
        end

        // Backpressure: response held while the core stalls; a request during the stall is ignored.
        model(1'b0, 2'b10, 32'h10, 1'b0, 32'h0, erd, eer);
        @(negedge clk);
        wait_ready();
        drive(1'b0, 2'b10, 32'h10, 1'b0, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b10, 32'h10, 1'b0, 32'h0);
            req_valid = 1'b1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, erd);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        run(1'b0, 2'b10, 32'h10, 1'b0, 32'h0, rd, er, erd, eer);
        chk("ignored_store_rdata", rd, erd);

        reset_in_wait(1'b0, 32'h10, 32'h0);
        reset_in_wait(1'b1, 32'h20, 32'hCAFEF00D);
        run(1'b0, 2'b10, 32'h20, 1'b0, 32'h0, rd, er, erd, eer);
        chk("store_survives_reset", rd, 32'hCAFEF00D);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 15))
                0:       a = 32'(4*DEPTH) + 32'($urandom_range(0, 7));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 4*DEPTH-1));
            endcase
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run(1'($urandom_range(0, 1)), sz, a, 1'($urandom_range(0, 1)), $urandom, rd, er, erd, eer);
            chk("rand_rdata", rd, erd);
            chk("rand_err", 32'(er), 32'(eer));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
